// File: rtl/fifo_stream_reader_pkg.sv
// Shared definitions for the FIFO read-side drain engine.
package fifo_stream_reader_pkg;

    // Data word width, matching the synchronous FIFO default.
    localparam int unsigned FIFO_WIDTH = 8;
    // Words the skid buffer holds; also the cap on buffered plus in-flight words.
    localparam int unsigned BUF_DEPTH  = 2;
    // Default width of the delivered-word counter.
    localparam int unsigned XFER_CNT_W = 16;

    // Buffer occupancy, 0..BUF_DEPTH.
    typedef logic [1:0] occ_t;

endpackage

// File: rtl/fifo_stream_reader_if.sv
// Valid/ready word stream between the drain engine and its consumer.
interface fifo_stream_reader_if #(
    parameter int unsigned WIDTH = 8
) ();

    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/fifo_stream_reader_skid_buf.sv
// Two-entry in-order buffer; the head entry drives the stream outputs directly.
module fifo_stream_reader_skid_buf
    import fifo_stream_reader_pkg::*;
#(
    parameter int unsigned WIDTH = FIFO_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data,
    output occ_t             occ
);

    logic [WIDTH-1:0] tail_q;
    logic [WIDTH-1:0] head_d;
    logic [WIDTH-1:0] tail_d;
    occ_t             occ_d;

    // Next-state: a landing word joins behind the head, or becomes head if the head leaves.
    always_comb begin
        head_d = head_data;
        tail_d = tail_q;
        occ_d  = occ;
        case (occ)
            2'd0: begin
                if (push) begin
                    head_d = push_data;
                    occ_d  = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_d = push_data;
                end else if (push) begin
                    tail_d = push_data;
                    occ_d  = 2'd2;
                end else if (pop) begin
                    occ_d  = 2'd0;
                end
            end
            default: begin
                if (pop) begin
                    head_d = tail_q;
                    if (push) begin
                        tail_d = push_data;
                    end else begin
                        occ_d  = 2'd1;
                    end
                end
            end
        endcase
    end

    // Buffer registers; valid is registered from the next occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ        <= '0;
            head_valid <= 1'b0;
            head_data  <= '0;
            tail_q     <= '0;
        end else begin
            occ        <= occ_d;
            head_valid <= (occ_d != 2'd0);
            head_data  <= head_d;
            tail_q     <= tail_d;
        end
    end

    // Occupancy must stay within 0..BUF_DEPTH.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (occ == occ_t'(BUF_DEPTH))));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(pop && (occ == 2'd0)));

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side drain engine: pops a synchronous FIFO and streams words out on valid/ready.
module fifo_stream_reader
    import fifo_stream_reader_pkg::*;
#(
    parameter int unsigned WIDTH = FIFO_WIDTH,
    parameter int unsigned CNT_W = XFER_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 fifo_empty,
    output logic                 fifo_read,
    input  logic [WIDTH-1:0]     fifo_data,
    fifo_stream_reader_if.master m,
    output logic [CNT_W-1:0]     xfer_count,
    output logic                 idle
);

    occ_t             occ;
    logic             inflight;
    logic             pop;
    logic [2:0]       occ_after;
    logic             head_valid;
    logic [WIDTH-1:0] head_data;

    // Issue a read only when the word it returns is guaranteed a buffer slot;
    // m.ready feeds in combinationally so a pop frees its slot in the same cycle.
    always_comb begin
        pop       = head_valid & m.ready;
        occ_after = 3'(occ) + 3'(inflight) - 3'(pop);
        fifo_read = en & ~fifo_empty & ~rst & (occ_after < 3'(BUF_DEPTH));
        idle      = (occ == 2'd0) & ~inflight & (~en | fifo_empty);
    end

    // Read data arrives one cycle after the strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_read;
        end
    end

    // Count accepted output words, wrapping at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_count <= '0;
        end else if (pop) begin
            xfer_count <= xfer_count + CNT_W'(1);
        end
    end

    fifo_stream_reader_skid_buf #(
        .WIDTH (WIDTH)
    ) u_skid_buf (
        .clk        (clk),
        .rst        (rst),
        .push       (inflight),
        .push_data  (fifo_data),
        .pop        (pop),
        .head_valid (head_valid),
        .head_data  (head_data),
        .occ        (occ)
    );

    assign m.valid = head_valid;
    assign m.data  = head_data;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: FIFO model, scoreboard queue, negedge monitor.
module tb_fifo_stream_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        m_ready;
    logic        hold_empty;
    logic        fifo_flush;
    logic        fifo_empty;
    logic        fifo_read;
    logic        fifo_read4;
    logic [7:0]  fifo_data;
    logic [15:0] xfer_count;
    logic [3:0]  xfer_count4;
    logic        idle;
    logic        idle4;

    logic [7:0]  mem [0:4095];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic [7:0]  exp_q [$];
    int          total = 0;
    int          bad = 0;
    int          n_acc = 0;
    logic        stall_prev = 1'b0;
    logic [7:0]  held = '0;

    fifo_stream_reader_if #(.WIDTH(8)) sif ();
    fifo_stream_reader_if #(.WIDTH(8)) sif4 ();

    assign sif.ready  = m_ready;
    assign sif4.ready = m_ready;
    assign fifo_empty = hold_empty || (wr_ptr == rd_ptr);

    fifo_stream_reader #(.WIDTH(8), .CNT_W(16)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_read  (fifo_read),
        .fifo_data  (fifo_data),
        .m          (sif.master),
        .xfer_count (xfer_count),
        .idle       (idle)
    );

    fifo_stream_reader #(.WIDTH(8), .CNT_W(4)) u_dut4 (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_read  (fifo_read4),
        .fifo_data  (fifo_data),
        .m          (sif4.master),
        .xfer_count (xfer_count4),
        .idle       (idle4)
    );

    always #5 clk = ~clk;

    // Synchronous FIFO model with one-cycle registered read data.
    always @(posedge clk) begin
        if (fifo_flush) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_read && !fifo_empty) begin
            fifo_data <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: handshakes seen mid-cycle complete at the next posedge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("read_when_empty", {31'd0, fifo_read & fifo_empty}, 32'd0);
            chk("cnt4_twin", {30'd0, fifo_read4, idle4}, {30'd0, fifo_read, idle});
            if (stall_prev) begin
                chk("stall_valid", {31'd0, sif.valid}, 32'd1);
                chk("stall_data", {24'd0, sif.data}, {24'd0, held});
            end
            if (sif.valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", {24'd0, sif.data}, 32'hffff_ffff);
                end else begin
                    chk("sb_data", {24'd0, sif.data}, {24'd0, exp_q.pop_front()});
                end
                n_acc++;
            end
            stall_prev = sif.valid && !m_ready;
            held       = sif.data;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [7:0] d);
        mem[wr_ptr] = d;
        wr_ptr++;
        exp_q.push_back(d);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || !idle) && n < budget) begin
            drive_edge();
            n++;
        end
        chk("drain_in_budget", {31'd0, (n < budget)}, 32'd1);
    endtask

    initial begin
        int reads;
        int pushed;
        int cyc;
        rst        = 1'b1;
        en         = 1'b1;
        m_ready    = 1'b1;
        hold_empty = 1'b0;
        fifo_flush = 1'b0;
        fifo_data  = '0;

        // Reset with a non-empty FIFO, then stream 0x01..0x10
        for (int i = 1; i <= 16; i++) push_word(8'(i));
        repeat (3) begin
            drive_edge();
            chk("rst_read", {31'd0, fifo_read}, 32'd0);
            chk("rst_valid", {31'd0, sif.valid}, 32'd0);
            chk("rst_count", {16'd0, xfer_count}, 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("first_read", {31'd0, fifo_read}, 32'd1);
        @(negedge clk);
        chk("latency_gap", {31'd0, sif.valid}, 32'd0);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk("stream_valid", {31'd0, sif.valid}, 32'd1);
            chk("stream_data", {24'd0, sif.data}, 32'(k + 1));
        end
        @(negedge clk);
        chk("stream_idle", {31'd0, idle}, 32'd1);
        chk("stream_count", {16'd0, xfer_count}, 32'd16);
        chk("stream_count4", {28'd0, xfer_count4}, 32'd0);

        // Backpressure: 10 stalled cycles, then release
        drive_edge();
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) push_word(8'(8'h21 + i));
        reads = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (fifo_read) reads++;
            if (i >= 2) chk("bp_hold", {23'd0, sif.valid, sif.data}, {23'd0, 1'b1, 8'h21});
            if (i < 9) drive_edge();
        end
        chk("bp_reads", 32'(reads), 32'd2);
        drive_edge();
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("bp_nogap", {31'd0, sif.valid}, 32'd1);
            if (i < 7) drive_edge();
        end
        wait_drain(20);

        // en dropped the cycle after a read: that word still arrives, no further reads
        drive_edge();
        for (int i = 0; i < 4; i++) push_word(8'(8'h31 + i));
        @(negedge clk);
        chk("en_first_read", {31'd0, fifo_read}, 32'd1);
        drive_edge();
        en = 1'b0;
        @(negedge clk);
        chk("en_noread", {31'd0, fifo_read}, 32'd0);
        drive_edge();
        @(negedge clk);
        chk("en_word", {23'd0, sif.valid, sif.data}, {23'd0, 1'b1, 8'h31});
        for (int i = 0; i < 5; i++) begin
            drive_edge();
            @(negedge clk);
            chk("en_stopped", {31'd0, fifo_read}, 32'd0);
        end
        chk("en_idle", {30'd0, sif.valid, idle}, 32'd1);
        drive_edge();
        en = 1'b1;
        wait_drain(20);

        // Random ready and FIFO underrun with 1000 words
        pushed = 0;
        cyc    = 0;
        while (pushed < 1000 && cyc < 20000) begin
            drive_edge();
            cyc++;
            if ($urandom_range(0, 2) != 0) begin
                push_word(8'(pushed * 7 + 3));
                pushed++;
                if (pushed < 1000 && $urandom_range(0, 3) == 0) begin
                    push_word(8'(pushed * 7 + 3));
                    pushed++;
                end
            end
            m_ready    = 1'($urandom_range(0, 1));
            hold_empty = ($urandom_range(0, 3) == 0);
        end
        drive_edge();
        m_ready    = 1'b1;
        hold_empty = 1'b0;
        wait_drain(3000);
        chk("rand_count", {16'd0, xfer_count}, {16'd0, 16'(n_acc)});
        chk("rand_count4", {28'd0, xfer_count4}, {28'd0, 4'(n_acc)});

        // Reset with one word buffered and one landing
        drive_edge();
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_word(8'(8'h41 + i));
        drive_edge();
        drive_edge();
        rst        = 1'b1;
        fifo_flush = 1'b1;
        exp_q.delete();
        drive_edge();
        chk("mrst_valid", {31'd0, sif.valid}, 32'd0);
        chk("mrst_count", {16'd0, xfer_count}, 32'd0);
        chk("mrst_count4", {28'd0, xfer_count4}, 32'd0);
        rst        = 1'b0;
        fifo_flush = 1'b0;
        n_acc      = 0;
        drive_edge();
        chk("mrst_landing_dropped", {31'd0, sif.valid}, 32'd0);

        // Restart with 17 words: 4-bit counter wraps to 1
        m_ready = 1'b1;
        for (int i = 0; i < 17; i++) push_word(8'(8'h60 + i));
        wait_drain(60);
        chk("wrap_count", {16'd0, xfer_count}, 32'd17);
        chk("wrap_count4", {28'd0, xfer_count4}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Run bound
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
